// File: rtl/muxsq_pkg.sv
// muxsq_pkg -- shared definitions for the muxsq_n_1 registered N:1 channel mux.
//   MODE_FIXED / MODE_RR : values of the ps_mode select input.
//   GCNT_W               : width of each per-channel grant counter
//                          (counters exist only when MUXSQ_GCNT_EN is defined).
//   rr_first()           : rotate-priority first-set search used by the arbiter.
package muxsq_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  localparam int GCNT_W = 16;

  // Largest supported channel count; rr_first works on a vector this wide.
  localparam int MAX_CH = 16;
  localparam int IDX_W  = 4;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } rr_grant_t;

  // Returns the first set bit of req[0 +: n], scanning ptr, ptr+1, ... mod n.
  // ptr must be below n; bits of req at or above n are ignored.
  function automatic rr_grant_t rr_first(input logic [MAX_CH-1:0] req,
                                         input logic [IDX_W-1:0]  ptr,
                                         input int                n);
    rr_grant_t res;
    int        k;
    res = '0;
    for (int i = 0; i < MAX_CH; i++) begin
      if (i < n) begin
        // ptr < n and i < n, so one conditional subtract gives the modulo.
        k = int'(ptr) + i;
        if (k >= n) k = k - n;
        if (!res.found && req[k]) begin
          res.found = 1'b1;
          res.idx   = IDX_W'(k);
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/muxsq_rr_arb.sv
// muxsq_rr_arb -- NCH-wide rotating-priority arbiter (purely combinational).
// Ports:
//   req   [NCH-1:0] : request vector (one bit per channel).
//   ptr   [SW-1:0]  : highest-priority channel this cycle.
//   grant [SW-1:0]  : granted channel index (meaningful only when found=1).
//   found           : at least one request was present.
module muxsq_rr_arb
  import muxsq_pkg::*;
#(
  parameter  int NCH = 4,
  localparam int SW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [NCH-1:0] req,
  input  logic [SW-1:0]  ptr,
  output logic [SW-1:0]  grant,
  output logic           found
);

  logic [MAX_CH-1:0] req_ext;
  rr_grant_t         res;

  always_comb begin
    // NOTE: every always_comb output gets a default before any conditional
    // logic, so no path leaves it unassigned and no latch is inferred.
    req_ext            = '0;
    req_ext[NCH-1:0]   = req;
    res                = rr_first(req_ext, IDX_W'(ptr), NCH);
    grant              = SW'(res.idx);
    found              = res.found;
  end

endmodule

// File: rtl/muxsq_n_1.sv
// muxsq_n_1 -- registered N:1 channel multiplexer with valid/ready handshakes.
// Channels are chosen either by an external select (fixed mode) or by a fair
// rotating-priority arbiter (round-robin mode). The selected beat is captured
// in a one-beat output register that supports full-throughput backpressure.
//
// Parameters: NCH (2..16 channels), DW (data width); SW is derived.
// Ports:
//   pclk, prst            : clock; synchronous active-high reset.
//   pi_data  [NCH*DW-1:0] : channel k data at [k*DW +: DW].
//   pi_valid [NCH-1:0]    : per-channel valid.
//   pi_ready [NCH-1:0]    : per-channel ready, one-hot or zero (combinational).
//   ps_mode               : MODE_FIXED (0) or MODE_RR (1).
//   ps_sel   [SW-1:0]     : channel select in fixed mode.
//   pout_data/pout_ch/pout_valid : registered output beat and its source.
//   pi_oready             : downstream ready.
// Optional build macro MUXSQ_GCNT_EN adds pout_gcnt [NCH*16-1:0], one
// saturating 16-bit grant counter per channel.
module muxsq_n_1
  import muxsq_pkg::*;
#(
  parameter  int NCH = 4,
  parameter  int DW  = 8,
  localparam int SW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              pclk,
  input  logic              prst,
  input  logic [NCH*DW-1:0] pi_data,
  input  logic [NCH-1:0]    pi_valid,
  output logic [NCH-1:0]    pi_ready,
  input  logic              ps_mode,
  input  logic [SW-1:0]     ps_sel,
  output logic [DW-1:0]     pout_data,
  output logic [SW-1:0]     pout_ch,
  output logic              pout_valid,
  input  logic              pi_oready
`ifdef MUXSQ_GCNT_EN
  ,
  output logic [NCH*GCNT_W-1:0] pout_gcnt
`endif
);

  logic [SW-1:0] rr_ptr;
  logic [SW-1:0] arb_grant;
  logic          arb_found;
  logic [SW-1:0] grant;
  logic          grant_found;
  logic          load_en;
  logic          xfer;
  logic [DW-1:0] sel_data;
  logic [SW-1:0] rr_next;

  muxsq_rr_arb #(.NCH(NCH)) u_arb (
    .req   (pi_valid),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .found (arb_found)
  );

  // The register can accept a beat when empty or when its beat leaves now.
  assign load_en = !pout_valid || pi_oready;

  always_comb begin
    grant       = arb_grant;
    grant_found = arb_found;
    if (ps_mode == MODE_FIXED) begin
      // Fixed mode grants regardless of valid; out-of-range selects grant
      // nothing (only possible when NCH is not a power of two).
      grant       = ps_sel;
      grant_found = ({1'b0, ps_sel} < (SW + 1)'(NCH));
    end
  end

  always_comb begin
    pi_ready = '0;
    if (!prst && grant_found && load_en) begin
      for (int k = 0; k < NCH; k++) begin
        if (grant == SW'(k)) pi_ready[k] = 1'b1;
      end
    end
  end

  assign xfer = |(pi_valid & pi_ready);

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NCH; k++) begin
      if (grant == SW'(k)) sel_data = pi_data[k*DW +: DW];
    end
  end

  assign rr_next = (grant == SW'(NCH - 1)) ? '0 : grant + SW'(1);

  always_ff @(posedge pclk) begin
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    if (prst) begin
      pout_valid <= 1'b0;
      pout_data  <= '0;
      pout_ch    <= '0;
      rr_ptr     <= '0;
    end else if (xfer) begin
      // Covers both EMPTY loads and FULL replace-on-drain in the same edge.
      pout_valid <= 1'b1;
      pout_data  <= sel_data;
      pout_ch    <= grant;
      if (ps_mode == MODE_RR) rr_ptr <= rr_next;
    end else if (pi_oready) begin
      pout_valid <= 1'b0;
    end
  end

`ifdef MUXSQ_GCNT_EN
  logic [GCNT_W-1:0] gcnt_q [NCH];

  always_ff @(posedge pclk) begin
    for (int k = 0; k < NCH; k++) begin
      if (prst) begin
        gcnt_q[k] <= '0;
      end else if (xfer && grant == SW'(k) && gcnt_q[k] != '1) begin
        gcnt_q[k] <= gcnt_q[k] + GCNT_W'(1);
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_gcnt
    assign pout_gcnt[g*GCNT_W +: GCNT_W] = gcnt_q[g];
  end
`endif

endmodule

// File: tb/tb_muxsq_n_1.sv
// tb_muxsq_n_1 -- directed self-checking bench for muxsq_n_1.
// A 4-channel instance exercises reset, fixed select, backpressure and
// round-robin; a 3-channel instance covers the out-of-range select.
// Inputs change #1 after a rising edge; outputs are sampled there too.
module tb_muxsq_n_1;

  logic        pclk = 1'b0;
  logic        prst;
  logic [31:0] pi_data;
  logic [3:0]  pi_valid;
  logic [3:0]  pi_ready;
  logic        ps_mode;
  logic [1:0]  ps_sel;
  logic [7:0]  pout_data;
  logic [1:0]  pout_ch;
  logic        pout_valid;
  logic        pi_oready;

  logic [23:0] p3_data;
  logic [2:0]  p3_valid;
  logic [2:0]  p3_ready;
  logic        p3_mode;
  logic [1:0]  p3_sel;
  logic [7:0]  p3_out_data;
  logic [1:0]  p3_out_ch;
  logic        p3_out_valid;
  logic        p3_oready;

`ifdef MUXSQ_GCNT_EN
  logic [63:0] gcnt;
  logic [47:0] gcnt3;
`endif

  int total = 0;
  int bad   = 0;

  int exp_rr[6]   = '{0, 1, 2, 3, 0, 1};
  int exp_skip[4] = '{1, 3, 1, 3};

  always #5 pclk = ~pclk;

  muxsq_n_1 #(.NCH(4), .DW(8)) dut (
    .pclk       (pclk),
    .prst       (prst),
    .pi_data    (pi_data),
    .pi_valid   (pi_valid),
    .pi_ready   (pi_ready),
    .ps_mode    (ps_mode),
    .ps_sel     (ps_sel),
    .pout_data  (pout_data),
    .pout_ch    (pout_ch),
    .pout_valid (pout_valid),
    .pi_oready  (pi_oready)
`ifdef MUXSQ_GCNT_EN
    ,
    .pout_gcnt  (gcnt)
`endif
  );

  muxsq_n_1 #(.NCH(3), .DW(8)) dut3 (
    .pclk       (pclk),
    .prst       (prst),
    .pi_data    (p3_data),
    .pi_valid   (p3_valid),
    .pi_ready   (p3_ready),
    .ps_mode    (p3_mode),
    .ps_sel     (p3_sel),
    .pout_data  (p3_out_data),
    .pout_ch    (p3_out_ch),
    .pout_valid (p3_out_valid),
    .pi_oready  (p3_oready)
`ifdef MUXSQ_GCNT_EN
    ,
    .pout_gcnt  (gcnt3)
`endif
  );

  task automatic next_edge();
    @(posedge pclk);
    #1;
  endtask

  task automatic do_reset();
    prst = 1'b1;
    next_edge();
    prst = 1'b0;
  endtask

  task automatic test_reset();
    prst = 1'b1; pi_valid = 4'hF; pi_oready = 1'b1; pi_data = 32'hDEADBEEF;
    ps_mode = 1'b0; ps_sel = 2'd0;
    p3_data = 24'h0; p3_valid = 3'b000; p3_mode = 1'b0; p3_sel = 2'd0; p3_oready = 1'b1;
    repeat (2) next_edge();
    total++; if (pout_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", pout_valid); end
    total++; if (pout_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", pout_data); end
    total++; if (pout_ch !== 2'd0) begin bad++; $display("FAIL reset_ch: got %0d want 0", pout_ch); end
    total++; if (pi_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready: got %b want 0000", pi_ready); end
    prst = 1'b0; pi_valid = 4'h0;
    next_edge();
    total++; if (pout_valid !== 1'b0) begin bad++; $display("FAIL idle_valid: got %b want 0", pout_valid); end
  endtask

  task automatic test_fixed();
    ps_mode = 1'b0; ps_sel = 2'd2; pi_valid = 4'b0100; pi_data = 32'h00A5_0000; pi_oready = 1'b1;
    #1;
    total++; if (pi_ready !== 4'b0100) begin bad++; $display("FAIL fixed_ready: got %b want 0100", pi_ready); end
    next_edge();
    total++; if (pout_valid !== 1'b1) begin bad++; $display("FAIL fixed_valid: got %b want 1", pout_valid); end
    total++; if (pout_data !== 8'hA5) begin bad++; $display("FAIL fixed_data: got %h want a5", pout_data); end
    total++; if (pout_ch !== 2'd2) begin bad++; $display("FAIL fixed_ch: got %0d want 2", pout_ch); end
  endtask

  task automatic test_backpressure();
    pi_oready = 1'b0; pi_data = 32'h003C_0000;
    #1;
    total++; if (pi_ready !== 4'b0000) begin bad++; $display("FAIL bp_ready: got %b want 0000", pi_ready); end
    for (int i = 0; i < 3; i++) begin
      next_edge();
      total++; if (pout_data !== 8'hA5) begin bad++; $display("FAIL bp_hold_data[%0d]: got %h want a5", i, pout_data); end
      total++; if (pout_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", i, pout_valid); end
      total++; if (pi_ready !== 4'b0000) begin bad++; $display("FAIL bp_hold_ready[%0d]: got %b want 0000", i, pi_ready); end
    end
    pi_oready = 1'b1;
    #1;
    total++; if (pi_ready !== 4'b0100) begin bad++; $display("FAIL bp_release_ready: got %b want 0100", pi_ready); end
    next_edge();
    total++; if (pout_data !== 8'h3C) begin bad++; $display("FAIL bp_new_data: got %h want 3c", pout_data); end
    total++; if (pout_valid !== 1'b1) begin bad++; $display("FAIL bp_new_valid: got %b want 1", pout_valid); end
    pi_valid = 4'b0000;
    next_edge();
    total++; if (pout_valid !== 1'b0) begin bad++; $display("FAIL bp_drain_valid: got %b want 0", pout_valid); end
  endtask

  task automatic test_round_robin();
    logic [7:0] dexp;
    do_reset();
    ps_mode = 1'b1; pi_valid = 4'hF; pi_data = 32'h4433_2211; pi_oready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      total++; if (pi_ready !== 4'(1 << exp_rr[i])) begin bad++; $display("FAIL rr_ready[%0d]: got %b want %b", i, pi_ready, 4'(1 << exp_rr[i])); end
      next_edge();
      dexp = 8'((exp_rr[i] + 1) * 8'h11);
      total++; if (pout_ch !== 2'(exp_rr[i])) begin bad++; $display("FAIL rr_ch[%0d]: got %0d want %0d", i, pout_ch, exp_rr[i]); end
      total++; if (pout_data !== dexp) begin bad++; $display("FAIL rr_data[%0d]: got %h want %h", i, pout_data, dexp); end
      total++; if (pout_valid !== 1'b1) begin bad++; $display("FAIL rr_valid[%0d]: got %b want 1", i, pout_valid); end
    end
    pi_valid = 4'h0;
`ifdef MUXSQ_GCNT_EN
    total++; if (gcnt !== {16'd1, 16'd1, 16'd2, 16'd2}) begin bad++; $display("FAIL rr_gcnt: got %h want 0001000100020002", gcnt); end
`endif
    next_edge();
    total++; if (pout_valid !== 1'b0) begin bad++; $display("FAIL rr_drain_valid: got %b want 0", pout_valid); end
  endtask

  task automatic test_rr_skip();
    logic [7:0] dexp;
    do_reset();
    ps_mode = 1'b1; pi_valid = 4'b1010; pi_data = 32'h4433_2211; pi_oready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (pi_ready !== 4'(1 << exp_skip[i])) begin bad++; $display("FAIL skip_ready[%0d]: got %b want %b", i, pi_ready, 4'(1 << exp_skip[i])); end
      next_edge();
      dexp = 8'((exp_skip[i] + 1) * 8'h11);
      total++; if (pout_ch !== 2'(exp_skip[i])) begin bad++; $display("FAIL skip_ch[%0d]: got %0d want %0d", i, pout_ch, exp_skip[i]); end
      total++; if (pout_data !== dexp) begin bad++; $display("FAIL skip_data[%0d]: got %h want %h", i, pout_data, dexp); end
    end
    pi_valid = 4'b0000;
    #1;
    total++; if (pi_ready !== 4'b0000) begin bad++; $display("FAIL skip_idle_ready: got %b want 0000", pi_ready); end
    total++; if (pout_valid !== 1'b1) begin bad++; $display("FAIL skip_last_valid: got %b want 1", pout_valid); end
    next_edge();
    total++; if (pout_valid !== 1'b0) begin bad++; $display("FAIL skip_drop_valid: got %b want 0", pout_valid); end
  endtask

  task automatic test_out_of_range();
    do_reset();
    p3_mode = 1'b0; p3_sel = 2'd3; p3_valid = 3'b111; p3_data = 24'hCC_BBAA; p3_oready = 1'b1;
    #1;
    total++; if (p3_ready !== 3'b000) begin bad++; $display("FAIL oor_ready: got %b want 000", p3_ready); end
    next_edge();
    total++; if (p3_out_valid !== 1'b0) begin bad++; $display("FAIL oor_valid: got %b want 0", p3_out_valid); end
    p3_sel = 2'd1;
    #1;
    total++; if (p3_ready !== 3'b010) begin bad++; $display("FAIL inrange_ready: got %b want 010", p3_ready); end
    next_edge();
    total++; if (p3_out_valid !== 1'b1) begin bad++; $display("FAIL inrange_valid: got %b want 1", p3_out_valid); end
    total++; if (p3_out_ch !== 2'd1) begin bad++; $display("FAIL inrange_ch: got %0d want 1", p3_out_ch); end
    total++; if (p3_out_data !== 8'hBB) begin bad++; $display("FAIL inrange_data: got %h want bb", p3_out_data); end
    p3_valid = 3'b000;
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_backpressure();
    test_round_robin();
    test_rr_skip();
    test_out_of_range();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/muxsq_n_1.md
Name: muxsq_n_1

Overview:
Parametrised, registered N:1 channel multiplexer. Successor to the combinational 4:1 mux.
Adds per-channel valid/ready handshakes, a one-beat output register with backpressure, and two selection modes: fixed (external select) and round-robin (fair arbitration among valid channels).
Sits between several producer streams and a single consumer stream.

Parameters:
NCH, 4, number of input channels (2..16).
DW, 8, data width per channel in bits.
SW, $clog2(NCH), select/channel-index width (derived; not overridden).

Ports:
pclk  input  1  clock, all state on rising edge.
prst  input  1  synchronous active-high reset.
pi_data  input  NCH*DW  channel data; channel k occupies bits [k*DW +: DW].
pi_valid  input  NCH  per-channel valid.
pi_ready  output  NCH  per-channel ready (combinational, one-hot or zero).
ps_mode  input  1  0 = fixed select, 1 = round-robin.
ps_sel  input  SW  channel select, used only when ps_mode=0.
pout_data  output  DW  registered output data.
pout_ch  output  SW  index of the channel that supplied pout_data.
pout_valid  output  1  output beat valid.
pi_oready  input  1  downstream ready.

Behaviour:
- Reset (prst=1 at a pclk edge):
  - pout_valid=0, pout_data=0, pout_ch=0, round-robin pointer rr_ptr=0.
  - Any held beat is dropped.
  - pi_ready forced to all-zero while prst=1.
- Output register states:
  - EMPTY (pout_valid=0) and FULL (pout_valid=1).
  - load_en = !pout_valid | pi_oready.
- Grant (combinational):
  - Fixed mode: grant = ps_sel if ps_sel < NCH, else none.
  - Round-robin mode: grant is the first k with pi_valid[k]=1, scanning rr_ptr, rr_ptr+1, ... mod NCH. None if pi_valid=0.
- pi_ready[grant] = load_en. All other bits are 0.
  - In fixed mode, pi_ready[ps_sel] may be 1 while pi_valid[ps_sel]=0.
  - In round-robin mode, pi_ready is nonzero only when a valid channel exists.
- Transfer on channel g occurs when pi_valid[g] & pi_ready[g]. On the next edge:
  - pout_data = channel g data, pout_ch = g, pout_valid = 1.
  - In round-robin mode, rr_ptr = (g+1) mod NCH. In fixed mode, rr_ptr is unchanged.
- No transfer while load_en=1: pout_valid becomes 0 when pi_oready=1, otherwise it holds.
- FULL with pi_oready=0: pout_data, pout_ch and pout_valid are held stable. Input changes have no effect.
- FULL with pi_oready=1 and a transfer pending: the new beat replaces the old in the same edge. Throughput is 1 beat/cycle; latency is 1 cycle from input handshake to pout_valid.
- ps_mode/ps_sel changes take effect combinationally for the next transfer. They never alter a held beat.
- rr_ptr wraps from NCH-1 to 0.

Optional Feature:
MUXSQ_GCNT_EN:
- When defined, adds output port pout_gcnt [NCH*16-1:0]: per-channel 16-bit grant counters.
  - Each counter increments on every transfer from its channel.
  - Counters saturate at 16'hFFFF and clear to 0 on reset.
- When undefined, the port and counters are absent. All other behaviour is identical.

Decomposition:
- Shared package muxsq_pkg holds:
  - mode constants MODE_FIXED=1'b0 and MODE_RR=1'b1;
  - counter width constant GCNT_W=16;
  - a function computing the rotate-priority first-set index.
- One natural sub-module: muxsq_rr_arb (NCH-wide rotating-priority arbiter). Inputs: request vector and rr_ptr. Outputs: grant index and grant-found flag.
- Datapath and output register stay in the top.

Test Plan:
- Reset: prst=1 for 2 cycles with pi_valid=4'hF, pi_oready=1 -> pout_valid=0, pout_data=8'h00, pout_ch=0, pi_ready=4'b0000.
- Fixed select: ps_mode=0, ps_sel=2, pi_valid=4'b0100, ch2 data=8'hA5, pi_oready=1 -> pi_ready=4'b0100; next cycle pout_valid=1, pout_data=8'hA5, pout_ch=2.
- Backpressure: FULL with 8'hA5, pi_oready=0 for 3 cycles while ch2 data changes to 8'h3C -> pout_data stays 8'hA5 and pi_ready=0. Raise pi_oready -> 8'h3C appears the following cycle.
- Round-robin: ps_mode=1, pi_valid=4'hF, pi_oready=1 continuously -> pout_ch sequence 0,1,2,3,0, one beat per cycle.
- Round-robin skip: pi_valid=4'b1010 from reset -> pout_ch sequence 1,3,1,3. pi_valid=0 -> pout_valid drops after one cycle.
- Out-of-range select / counters: NCH=3, ps_mode=0, ps_sel=3 -> no transfer, pi_ready=0. With MUXSQ_GCNT_EN, after the round-robin test, counters for channels 0 and 1 read 2, channels 2 and 3 read 1.
